// File: rtl/exhaust_key_scheduler_if.sv
// Remote key request channel for the exhaust key scheduler.
// Requester drives valid/code, scheduler answers with ready.
interface exhaust_key_scheduler_if;
    logic       rem_valid;
    logic [1:0] rem_code;
    logic       rem_ready;

    modport master (
        output rem_valid,
        output rem_code,
        input  rem_ready
    );

    modport slave (
        input  rem_valid,
        input  rem_code,
        output rem_ready
    );
endinterface

// File: rtl/exhaust_key_scheduler.sv
// Debounced panel + remote key arbiter feeding the exhaust mode FSM.
// Remote channel and round-robin exist only with EXHAUST_REMOTE_EN.
module exhaust_key_scheduler #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int GAP_CYCLES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          is_on,
    input  logic [3:0]                    btn_raw,
    exhaust_key_scheduler_if.slave        rem,
    output logic                          menu_key,
    output logic                          level1_key,
    output logic                          level2_key,
    output logic                          level3_key,
    output logic                          key_src,
    output logic                          arb_busy,
    output logic                          panel_drop
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    logic [3:0]    sync1, sync2;
    logic [3:0]    cand, acc, acc_d, rise;
    logic [DW-1:0] db_cnt;
    logic          pan_ev;
    logic [1:0]    pan_ev_code;
    logic          pan_valid;
    logic [1:0]    pan_code;
    logic          rem_valid_q;
    logic [1:0]    rem_code_q;
    logic          rr_rem_last;
    state_t        state, state_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [3:0]    keys, keys_n;
    logic          src_q, src_n;
    logic          can_grant;
    logic          grant_pan, grant_rem;
    logic [1:0]    sel_code;

    // two-flop synchronizer for the asynchronous panel buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // shared debounce counter; power-off parks everything on the synced value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= 4'b0000;
            acc    <= 4'b0000;
            acc_d  <= 4'b0000;
            db_cnt <= '0;
        end else if (!is_on) begin
            cand   <= sync2;
            acc    <= sync2;
            acc_d  <= sync2;
            db_cnt <= '0;
        end else begin
            acc_d <= acc;
            if (sync2 != cand) begin
                cand   <= sync2;
                db_cnt <= DW'(1);
            end else if (db_cnt == DB_LAST) begin
                acc <= cand;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign rise = acc & ~acc_d;

    // rising accepted bits, menu has the highest priority
    always_comb begin
        pan_ev      = |rise;
        pan_ev_code = 2'd0;
        if (rise[0])
            pan_ev_code = 2'd0;
        else if (rise[1])
            pan_ev_code = 2'd1;
        else if (rise[2])
            pan_ev_code = 2'd2;
        else if (rise[3])
            pan_ev_code = 2'd3;
    end

    // one-entry panel slot; a grant on the same edge frees it for the event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_valid  <= 1'b0;
            pan_code   <= 2'd0;
            panel_drop <= 1'b0;
        end else if (!is_on) begin
            pan_valid <= 1'b0;
        end else if (pan_ev) begin
            if (pan_valid && !grant_pan) begin
                panel_drop <= 1'b1;
            end else begin
                pan_valid <= 1'b1;
                pan_code  <= pan_ev_code;
            end
        end else if (grant_pan) begin
            pan_valid <= 1'b0;
        end
    end

`ifdef EXHAUST_REMOTE_EN
    assign rem.rem_ready = is_on && !rem_valid_q;

    // one-entry remote slot loaded on a valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_valid_q <= 1'b0;
            rem_code_q  <= 2'd0;
        end else if (!is_on) begin
            rem_valid_q <= 1'b0;
        end else if (rem.rem_valid && !rem_valid_q) begin
            rem_valid_q <= 1'b1;
            rem_code_q  <= rem.rem_code;
        end else if (grant_rem) begin
            rem_valid_q <= 1'b0;
        end
    end

    // tie-break pointer, moves only when both sources were waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_rem_last <= 1'b1;
        else if (grant_pan && rem_valid_q)
            rr_rem_last <= 1'b0;
        else if (grant_rem && pan_valid)
            rr_rem_last <= 1'b1;
    end
`else
    logic unused_rem;

    assign rem.rem_ready = 1'b0;
    assign rem_valid_q   = 1'b0;
    assign rem_code_q    = 2'd0;
    assign rr_rem_last   = 1'b1;
    assign unused_rem    = ^{rem.rem_valid, rem.rem_code};
`endif

    // arbiter state, gap counter and registered key pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            keys    <= 4'b0000;
            src_q   <= 1'b0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
            keys    <= keys_n;
            src_q   <= src_n;
        end
    end

    // next state; the last gap cycle may grant directly to keep the period tight
    always_comb begin
        state_n   = state;
        gap_cnt_n = gap_cnt;
        keys_n    = 4'b0000;
        src_n     = 1'b0;
        can_grant = 1'b0;
        grant_pan = 1'b0;
        grant_rem = 1'b0;
        sel_code  = pan_code;
        unique case (state)
            IDLE: can_grant = 1'b1;
            ISSUE: begin
                state_n   = GAP;
                gap_cnt_n = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n   = IDLE;
                    can_grant = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (can_grant) begin
            if (pan_valid && (!rem_valid_q || rr_rem_last))
                grant_pan = 1'b1;
            else if (rem_valid_q)
                grant_rem = 1'b1;
        end
        if (grant_rem)
            sel_code = rem_code_q;
        if (grant_pan || grant_rem) begin
            state_n = ISSUE;
            src_n   = grant_rem;
            keys_n  = 4'b0001 << sel_code;
        end
        if (!is_on) begin
            state_n   = IDLE;
            gap_cnt_n = '0;
            keys_n    = 4'b0000;
            src_n     = 1'b0;
            grant_pan = 1'b0;
            grant_rem = 1'b0;
        end
    end

    assign menu_key   = keys[0];
    assign level1_key = keys[1];
    assign level2_key = keys[2];
    assign level3_key = keys[3];
    assign key_src    = src_q;
    assign arb_busy   = (state != IDLE);
endmodule

// File: doc/exhaust_key_scheduler.md
# exhaust_key_scheduler

Arbitrates and sequences key requests for the exhaust (range hood) mode controller. It takes raw, bouncy panel buttons and an optional remote request channel. It turns them into clean single-cycle, one-hot `menu_key` / `level1_key` / `level2_key` / `level3_key` pulses, with a guaranteed minimum spacing between pulses. It sits directly upstream of the exhaust mode state machine and shares that single key input port between the two request sources.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20: consecutive stable synced samples required to accept a panel change (≥2).
- `GAP_CYCLES`, default 4: idle cycles enforced after every issued pulse (≥1).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `is_on`  in  1  hood powered; low flushes the block and blocks all output
- `btn_raw`  in  4  raw panel buttons, asynchronous: [0] menu, [1] L1, [2] L2, [3] L3
- `rem_valid`  in  1  remote request valid
- `rem_code`  in  2  remote key code: 00 menu, 01 L1, 10 L2, 11 L3
- `rem_ready`  out  1  remote request slot free
- `menu_key`, `level1_key`, `level2_key`, `level3_key`  out  1 each  one-cycle key pulses, at most one high per cycle
- `key_src`  out  1  source of the current pulse (0 panel, 1 remote); meaningful only while a key pulse is high
- `arb_busy`  out  1  FSM not in IDLE
- `panel_drop`  out  1  sticky: a panel press was lost

## Operation
- **Panel path**
  - `btn_raw` passes through a 2-flop synchronizer.
  - A shared debounce counter resets whenever the synced vector differs from the candidate vector.
  - The accepted vector loads the candidate once the synced vector has equalled it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A rising bit in the accepted vector forms a panel event.
  - If several bits rise together, the event takes priority menu > L1 > L2 > L3; the other bits are discarded.
  - The event is written to the one-entry panel pending slot (valid + code).
  - If an event arrives while the slot is already valid, the event is discarded and `panel_drop` sets.
  - If an event arrives on the same edge the slot is granted, the new event is stored (set wins) and no drop occurs.
- **Remote path**
  - `rem_ready = is_on && !rem_pend_valid` (combinational).
  - A request is accepted on an edge where `rem_valid && rem_ready`; it loads the remote pending slot.
  - `rem_valid` may drop without an accept; no state changes in that case.
- **FSM** (states IDLE, ISSUE, GAP)
  - IDLE with no pending slot: stay in IDLE.
  - IDLE with exactly one pending slot: grant that slot.
  - IDLE with both slots pending: round-robin. The grant goes to the source not granted last; after reset, panel wins first.
  - Grant: clear the granted slot, go to ISSUE, and register the one-hot key pulse and `key_src`.
  - ISSUE: lasts exactly 1 cycle, then GAP.
  - GAP: lasts `GAP_CYCLES` cycles using a down-counter, then IDLE.
- **Power off**
  - While `is_on` is low: FSM forced to IDLE, both pending slots cleared, debounce state held at current synced value, no key pulses, no new events.
  - An in-flight pulse is cut off at the next edge.
- **Reset values**
  - All key outputs 0, `key_src` 0, `arb_busy` 0, `panel_drop` 0.
  - FSM in IDLE, slots empty, accepted vector 0000, round-robin pointer = remote (so the next tie goes to panel).
- `panel_drop` clears only on `rst`.

## Timing
- Remote accept at edge N with FSM in IDLE: key pulse is high from edge N+1 to edge N+2. `rem_ready` is low during cycle N to N+1 and returns high after edge N+1.
- Panel: clean press applied at edge 0:
  - synced value seen at edge 2;
  - accepted at edge 2+`DEBOUNCE_CYCLES`;
  - slot set at edge 3+`DEBOUNCE_CYCLES`;
  - pulse starts at edge 4+`DEBOUNCE_CYCLES`.
- Back-to-back pulses are separated by exactly `GAP_CYCLES` low cycles when requests are waiting. Minimum period is `GAP_CYCLES`+1.
- A button release is debounced the same way but generates no event.
- `rst` asserted mid-pulse clears all outputs immediately (asynchronous).

## Configuration
- `EXHAUST_REMOTE_EN` defined: remote channel and round-robin arbitration present as described.
- Not defined:
  - `rem_ready` tied 0; `rem_valid` and `rem_code` ignored; remote slot and round-robin pointer absent.
  - `key_src` is always 0.
  - Panel behaviour and all timing unchanged.

## Test plan
- `DEBOUNCE_CYCLES`=20. Press `btn_raw`=0010 with 3 bounces of 5 cycles, then hold stable → exactly one `level1_key` pulse, 24 edges after the last bounce ends, `key_src`=0.
- `rem_valid`=1 with `rem_code`=11 at edge 10, FSM idle → `level3_key` high for cycle 11–12 only, `rem_ready` low for exactly one cycle.
- Panel and remote slots both pending after reset → panel pulse first, then exactly `GAP_CYCLES`=4 low cycles, then the remote pulse. On the next tie, remote goes first.
- Two panel presses (L2, then L3) debounced while the FSM is in GAP with the slot still full → only L2 issued, `panel_drop`=1 and it stays 1.
- Drop `is_on` during GAP with a remote request pending → no further pulses, `rem_ready`=0. After `is_on` returns, a new request issues normally.
- Build without `EXHAUST_REMOTE_EN`, assert `rem_valid` with `rem_code`=00 for 50 cycles → `rem_ready`=0, no `menu_key` pulse.
